// File: rtl/ifetch_pc_sequencer_pkg.sv
// Shared definitions for the instruction-address sequencer: address width,
// sequencer state encodings and the default boot address.
package ifetch_pc_sequencer_pkg;

    localparam int WORD_LENGTH = 32;

    // Word address applied on reset unless the instance overrides it.
    localparam logic [0:WORD_LENGTH-1] DEFAULT_RESET_VEC = '0;

    // Two-bit state encoding; the fourth code is unused and recovers to boot.
    typedef enum logic [1:0] {
        SEQ_BOOT = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_WRAP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/ifetch_pc_sequencer_incrementer.sv
// Next-address datapath: adds one to the address and reports the carry out
// of the top bit, which flags a wrap past the end of the address space.
module ifetch_pc_sequencer_incrementer #(
    parameter int W = 32
) (
    input  logic [0:W-1] a,
    output logic [0:W-1] s,
    output logic         outC
);

    logic [W:0] sum;

    // Widen by one bit so the carry out is captured alongside the sum.
    always_comb begin
        sum  = {1'b0, a} + {{W{1'b0}}, 1'b1};
        s    = sum[W-1:0];
        outC = sum[W];
    end

endmodule

// File: rtl/ifetch_pc_sequencer.sv
// Instruction-address sequencer feeding the fetch stage. Issues one word
// address per accepted valid/ready transfer, takes branch redirects with top
// priority and traps a sequential wrap past the highest address.
module ifetch_pc_sequencer
    import ifetch_pc_sequencer_pkg::*;
#(
    parameter logic [0:WORD_LENGTH-1] RESET_VEC = DEFAULT_RESET_VEC,
    parameter int                     CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirectValid,
    input  logic [0:WORD_LENGTH-1] redirectAddr,
    input  logic                   fetchReady,
    output logic                   pcValid,
    output logic [0:WORD_LENGTH-1] pc,
    output logic                   wrapFault,
    output logic [CNT_W-1:0]       issueCount
);

    seq_state_e             state_reg, state_next;
    logic [0:WORD_LENGTH-1] pc_reg, pc_next;
    logic                   pc_valid_reg, pc_valid_next;
    logic                   wrap_fault_reg, wrap_fault_next;
    logic [CNT_W-1:0]       issue_cnt_reg, issue_cnt_next;

    logic [0:WORD_LENGTH-1] pc_inc;
    logic                   pc_carry;
    logic                   transfer;

    ifetch_pc_sequencer_incrementer #(
        .W (WORD_LENGTH)
    ) u_incrementer (
        .a    (pc_reg),
        .s    (pc_inc),
        .outC (pc_carry)
    );

    assign transfer = pc_valid_reg && fetchReady;

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= SEQ_BOOT;
            pc_reg         <= RESET_VEC;
            pc_valid_reg   <= 1'b0;
            wrap_fault_reg <= 1'b0;
            issue_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pc_valid_reg   <= pc_valid_next;
            wrap_fault_reg <= wrap_fault_next;
            issue_cnt_reg  <= issue_cnt_next;
        end
    end

    // Next-state and next-output logic; hold everything unless a case below
    // decides otherwise.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pc_valid_next   = pc_valid_reg;
        wrap_fault_next = wrap_fault_reg;
        issue_cnt_next  = issue_cnt_reg;

        case (state_reg)
            SEQ_BOOT: begin
                // A redirect seen while booting replaces the reset vector.
                state_next    = SEQ_RUN;
                pc_valid_next = 1'b1;
                if (redirectValid) begin
                    pc_next = redirectAddr;
                end
            end
            SEQ_RUN, SEQ_WRAP: begin
                if (redirectValid) begin
                    // Redirect wins over a concurrent transfer: the old pc is
                    // consumed and its increment is dropped.
                    state_next      = SEQ_RUN;
                    pc_next         = redirectAddr;
                    pc_valid_next   = 1'b1;
                    wrap_fault_next = 1'b0;
                    issue_cnt_next  = '0;
                end else if (state_reg == SEQ_RUN && transfer) begin
                    pc_next = pc_inc;
                    if (issue_cnt_reg != {CNT_W{1'b1}}) begin
                        issue_cnt_next = issue_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    if (pc_carry) begin
                        // Walked off the top of the address space: park until
                        // software redirects us somewhere sane.
                        state_next      = SEQ_WRAP;
                        pc_valid_next   = 1'b0;
                        wrap_fault_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next      = SEQ_BOOT;
                pc_next         = RESET_VEC;
                pc_valid_next   = 1'b0;
                wrap_fault_next = 1'b0;
                issue_cnt_next  = '0;
            end
        endcase
    end

    assign pcValid    = pc_valid_reg;
    assign pc         = pc_reg;
    assign wrapFault  = wrap_fault_reg;
    assign issueCount = issue_cnt_reg;

endmodule

// File: tb/tb_ifetch_pc_sequencer.sv
// Directed bench for the instruction-address sequencer: boot, stalls,
// redirects, wrap trap, counter saturation and asynchronous reset.
module tb_ifetch_pc_sequencer;

    localparam int W     = 32;
    localparam int CNT_W = 4;

    logic           clk;
    logic           rst_n;
    logic           redirectValid;
    logic [0:W-1]   redirectAddr;
    logic           fetchReady;
    logic           pcValid;
    logic [0:W-1]   pc;
    logic           wrapFault;
    logic [CNT_W-1:0] issueCount;

    int vec_cnt;
    int miscmp_cnt;

    ifetch_pc_sequencer #(
        .RESET_VEC (32'h0000_0000),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirectValid (redirectValid),
        .redirectAddr  (redirectAddr),
        .fetchReady    (fetchReady),
        .pcValid       (pcValid),
        .pc            (pc),
        .wrapFault     (wrapFault),
        .issueCount    (issueCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one cycle; outputs are then sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic v, input logic [31:0] a,
                             input logic wf, input logic [CNT_W-1:0] c);
        check_eq({tag, ".valid"}, 64'(pcValid), 64'(v));
        check_eq({tag, ".pc"}, 64'(pc), 64'(a));
        check_eq({tag, ".wrap"}, 64'(wrapFault), 64'(wf));
        check_eq({tag, ".cnt"}, 64'(issueCount), 64'(c));
    endtask

    initial begin
        vec_cnt       = 0;
        miscmp_cnt    = 0;
        rst_n         = 1'b0;
        redirectValid = 1'b0;
        redirectAddr  = '0;
        fetchReady    = 1'b0;
        step();
        step();
        check_all("reset", 1'b0, 32'h0, 1'b0, 4'd0);

        // Boot and sequential issue.
        rst_n      = 1'b1;
        fetchReady = 1'b1;
        step();
        check_all("boot", 1'b1, 32'h0, 1'b0, 4'd0);
        step();
        check_all("seq1", 1'b1, 32'h1, 1'b0, 4'd1);
        step();
        check_all("seq2", 1'b1, 32'h2, 1'b0, 4'd2);
        step();
        check_all("seq3", 1'b1, 32'h3, 1'b0, 4'd3);

        // Stalls: pc 10, ready 1,0,0,1.
        fetchReady    = 1'b0;
        redirectValid = 1'b1;
        redirectAddr  = 32'd10;
        step();
        redirectValid = 1'b0;
        check_all("rd10", 1'b1, 32'd10, 1'b0, 4'd0);
        fetchReady = 1'b1;
        step();
        check_all("stall_a", 1'b1, 32'd11, 1'b0, 4'd1);
        fetchReady = 1'b0;
        step();
        check_all("stall_b", 1'b1, 32'd11, 1'b0, 4'd1);
        step();
        check_all("stall_c", 1'b1, 32'd11, 1'b0, 4'd1);
        fetchReady = 1'b1;
        step();
        check_all("stall_d", 1'b1, 32'd12, 1'b0, 4'd2);

        // Wrap trap.
        redirectValid = 1'b1;
        redirectAddr  = 32'hFFFF_FFFE;
        step();
        redirectValid = 1'b0;
        check_all("rd_top", 1'b1, 32'hFFFF_FFFE, 1'b0, 4'd0);
        step();
        check_all("top", 1'b1, 32'hFFFF_FFFF, 1'b0, 4'd1);
        step();
        check_all("wrap", 1'b0, 32'h0, 1'b1, 4'd2);
        step();
        check_all("wrap_hold1", 1'b0, 32'h0, 1'b1, 4'd2);
        step();
        check_all("wrap_hold2", 1'b0, 32'h0, 1'b1, 4'd2);
        fetchReady    = 1'b0;
        redirectValid = 1'b1;
        redirectAddr  = 32'h100;
        step();
        redirectValid = 1'b0;
        check_all("wrap_exit", 1'b1, 32'h100, 1'b0, 4'd0);

        // Redirect colliding with a transfer of pc=7.
        redirectValid = 1'b1;
        redirectAddr  = 32'd5;
        step();
        redirectValid = 1'b0;
        fetchReady    = 1'b1;
        step();
        step();
        check_all("pre_coll", 1'b1, 32'd7, 1'b0, 4'd2);
        redirectValid = 1'b1;
        redirectAddr  = 32'h40;
        step();
        redirectValid = 1'b0;
        check_all("coll", 1'b1, 32'h40, 1'b0, 4'd0);
        step();
        check_all("post_coll", 1'b1, 32'h41, 1'b0, 4'd1);

        // 20 transfers: counter saturates at 15, pc lands on 0x55.
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq($sformatf("sat%0d.cnt", i), 64'(issueCount),
                     64'((i + 2 > 15) ? 15 : i + 2));
        end
        check_all("sat_end", 1'b1, 32'h55, 1'b0, 4'd15);

        // Asynchronous reset mid-cycle with a redirect pending.
        redirectValid = 1'b1;
        redirectAddr  = 32'h99;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 32'h0, 1'b0, 4'd0);
        redirectValid = 1'b0;
        step();
        step();
        check_all("rst_hold", 1'b0, 32'h0, 1'b0, 4'd0);
        rst_n = 1'b1;
        step();
        check_all("reboot", 1'b1, 32'h0, 1'b0, 4'd0);
        step();
        check_all("reboot_seq", 1'b1, 32'h1, 1'b0, 4'd1);

        // Redirect captured during boot replaces the reset vector.
        rst_n = 1'b0;
        step();
        rst_n         = 1'b1;
        redirectValid = 1'b1;
        redirectAddr  = 32'h200;
        step();
        redirectValid = 1'b0;
        check_all("boot_rd", 1'b1, 32'h200, 1'b0, 4'd0);
        step();
        check_all("boot_rd_seq", 1'b1, 32'h201, 1'b0, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
